// File: rtl/chan_regfifo_pkg.sv
// Shared widths, status-byte layout and a constant clog2 helper for the chan_regfifo slice.
package chan_regfifo_pkg;

   localparam int CHAN_W         = 7;
   localparam int DATA_W         = 8;
   localparam int COUNT_W        = 6;
   localparam int STAT_FULL_BIT  = 7;
   localparam int STAT_EMPTY_BIT = 6;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/chan_regfifo_fifo_fwft.sv
// First-word-fall-through FIFO: head is presented combinationally while not empty,
// occupancy is a separate counter so full and empty are unambiguous.
module fifo_fwft
   import chan_regfifo_pkg::clog2;
   import chan_regfifo_pkg::COUNT_W;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               i_push,
   input  logic [DATA_W-1:0]  i_data,
   input  logic               i_pop,
   input  logic               i_flush,
   output logic               o_full,
   output logic               o_empty,
   output logic [COUNT_W-1:0] o_count,
   output logic [DATA_W-1:0]  o_head
);

   localparam int                 AW        = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam logic [COUNT_W-1:0] DEPTH_CNT = COUNT_W'(DEPTH);

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [COUNT_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == DEPTH_CNT);
   assign w_empty = (r_count == '0);
   // No bypass: a push into a full FIFO or a pop from an empty one is simply ignored.
   assign w_push  = i_push && !w_full && !i_flush;
   assign w_pop   = i_pop && !w_empty && !i_flush;

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + COUNT_W'(w_push) - COUNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;
   assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/chan_regfifo.sv
// Channel-mapped register bank, loopback FIFO and status byte behind the comm_fpga_fx2 channel bus.
// Define CHAN_REGFIFO_FLUSH_EN to make any write to the status channel empty the FIFO.
module chan_regfifo
   import chan_regfifo_pkg::*;
#(
   parameter int NUM_REGS   = 8,
   parameter int FIFO_CHAN  = 64,
   parameter int STAT_CHAN  = 65,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                       clk_in,
   input  logic                       reset_in,
   input  logic [CHAN_W-1:0]          chanAddr_in,
   input  logic [DATA_W-1:0]          h2fData_in,
   input  logic                       h2fValid_in,
   output logic                       h2fReady_out,
   output logic [DATA_W-1:0]          f2hData_out,
   output logic                       f2hValid_out,
   input  logic                       f2hReady_in,
   output logic [DATA_W*NUM_REGS-1:0] regs_out,
   output logic [COUNT_W-1:0]         fifoCount_out
);

   localparam logic [CHAN_W-1:0] FIFO_ADDR = CHAN_W'(FIFO_CHAN);
   localparam logic [CHAN_W-1:0] STAT_ADDR = CHAN_W'(STAT_CHAN);
   localparam logic [CHAN_W-1:0] NREG_ADDR = CHAN_W'(NUM_REGS);

   logic [DATA_W-1:0]  r_regs [NUM_REGS];

   logic               w_sel_reg;
   logic               w_sel_fifo;
   logic               w_sel_stat;
   logic               w_reg_wr;
   logic               w_push;
   logic               w_pop;
   logic               w_flush;
   logic               w_full;
   logic               w_empty;
   logic [COUNT_W-1:0] w_count;
   logic [DATA_W-1:0]  w_head;
   logic [DATA_W-1:0]  w_reg_rd;
   logic [DATA_W-1:0]  w_stat;

   assign w_sel_reg  = (chanAddr_in < NREG_ADDR);
   assign w_sel_fifo = (chanAddr_in == FIFO_ADDR);
   assign w_sel_stat = (chanAddr_in == STAT_ADDR);

   // Register channels and unmapped channels are always ready, so valid alone accepts.
   assign w_reg_wr = w_sel_reg && h2fValid_in;
   assign w_push   = w_sel_fifo && h2fValid_in && !w_full;
   assign w_pop    = w_sel_fifo && f2hReady_in && !w_empty;

`ifdef CHAN_REGFIFO_FLUSH_EN
   assign w_flush = w_sel_stat && h2fValid_in;
`else
   assign w_flush = 1'b0;
`endif

   fifo_fwft #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .i_push   (w_push),
      .i_data   (h2fData_in),
      .i_pop    (w_pop),
      .i_flush  (w_flush),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (w_count),
      .o_head   (w_head)
   );

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_reg_wr) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (chanAddr_in == CHAN_W'(i)) r_regs[i] <= h2fData_in;
         end
      end
   end

   always_comb begin
      w_reg_rd = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (chanAddr_in == CHAN_W'(i)) w_reg_rd = r_regs[i];
      end
   end

   always_comb begin
      w_stat                  = '0;
      w_stat[COUNT_W-1:0]     = w_count;
      w_stat[STAT_EMPTY_BIT]  = w_empty;
      w_stat[STAT_FULL_BIT]   = w_full;
   end

   // Outputs depend only on the channel address and stored state, never on valid/ready inputs.
   always_comb begin
      h2fReady_out = 1'b1;
      f2hValid_out = 1'b1;
      f2hData_out  = '0;
      if (w_sel_reg) begin
         f2hData_out = w_reg_rd;
      end else if (w_sel_fifo) begin
         h2fReady_out = !w_full;
         f2hValid_out = !w_empty;
         f2hData_out  = w_head;
      end else if (w_sel_stat) begin
         f2hData_out = w_stat;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[DATA_W*g +: DATA_W] = r_regs[g];
   end

   assign fifoCount_out = w_count;

endmodule

// File: tb/tb_chan_regfifo.sv
// Directed bench for chan_regfifo with a queue-based reference model checked every cycle.
module tb_chan_regfifo;

   localparam int NR = 8;
   localparam int FC = 64;
   localparam int SC = 65;
   localparam int FD = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [6:0]    chanAddr = '0;
   logic [7:0]    h2fData = '0;
   logic          h2fValid = 1'b0;
   logic          h2fReady;
   logic [7:0]    f2hData;
   logic          f2hValid;
   logic          f2hReady = 1'b0;
   logic [NR*8-1:0] regs_out;
   logic [5:0]    fifoCount;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic [7:0] mregs [NR];
   logic [7:0] q [$];

   always #5 clk = ~clk;

   chan_regfifo #(
      .NUM_REGS   (NR),
      .FIFO_CHAN  (FC),
      .STAT_CHAN  (SC),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk_in        (clk),
      .reset_in      (reset_n),
      .chanAddr_in   (chanAddr),
      .h2fData_in    (h2fData),
      .h2fValid_in   (h2fValid),
      .h2fReady_out  (h2fReady),
      .f2hData_out   (f2hData),
      .f2hValid_out  (f2hValid),
      .f2hReady_in   (f2hReady),
      .regs_out      (regs_out),
      .fifoCount_out (fifoCount)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic exp_ready(input logic [6:0] a);
      if (a == FC) return (q.size() < FD);
      return 1'b1;
   endfunction

   function automatic logic exp_valid(input logic [6:0] a);
      if (a == FC) return (q.size() > 0);
      return 1'b1;
   endfunction

   function automatic logic [7:0] exp_data(input logic [6:0] a);
      if (a < NR) return mregs[a[2:0]];
      if (a == FC) return (q.size() > 0) ? q[0] : 8'h00;
      if (a == SC) return {(q.size() == FD), (q.size() == 0), 6'(q.size())};
      return 8'h00;
   endfunction

   task automatic mreset();
      for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
      q.delete();
   endtask

   always @(negedge clk) begin : cmp
      logic [63:0] er;
      if (chk_en) begin
         for (int i = 0; i < NR; i++) er[8*i +: 8] = mregs[i];
         chk("regs_out", regs_out, er);
         chk("fifoCount", fifoCount, q.size());
         chk("h2fReady", h2fReady, exp_ready(chanAddr));
         chk("f2hValid", f2hValid, exp_valid(chanAddr));
         chk("f2hData", f2hData, exp_data(chanAddr));
      end
   end

   task automatic step(input logic [6:0] a, input logic hv, input logic [7:0] hd, input logic fr);
      bit dowr, dopush, dopop, doflush;
      @(negedge clk);
      #1;
      chanAddr = a;
      h2fValid = hv;
      h2fData  = hd;
      f2hReady = fr;
      dowr    = hv && (a < NR);
      dopush  = hv && (a == FC) && (q.size() < FD);
      dopop   = fr && (a == FC) && (q.size() > 0);
      doflush = 1'b0;
`ifdef CHAN_REGFIFO_FLUSH_EN
      doflush = hv && (a == SC);
`endif
      @(posedge clk);
      if (reset_n) begin
         if (dowr) mregs[a[2:0]] = hd;
         if (doflush) q.delete();
         else begin
            if (dopop) void'(q.pop_front());
            if (dopush) q.push_back(hd);
         end
      end
   endtask

   task automatic look(input logic [6:0] a);
      @(negedge clk);
      #1;
      chanAddr = a;
      h2fValid = 1'b0;
      f2hReady = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      int guard;
      mreset();
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      look(7'd0);
      chk("rst_h2fReady", h2fReady, 1);
      chk("rst_f2hValid", f2hValid, 1);
      chk("rst_regs", regs_out, 0);
      chk("rst_count", fifoCount, 0);
      chk("rst_data0", f2hData, 8'h00);
      look(7'(SC));
      chk("rst_status", f2hData, 8'h40);

      // Register path
      step(7'd3, 1'b1, 8'hA5, 1'b0);
      step(7'd0, 1'b1, 8'h5A, 1'b0);
      look(7'd0);
      chk("reg3_out", regs_out[31:24], 8'hA5);
      chk("reg0_out", regs_out[7:0], 8'h5A);
      chk("reg0_rd", f2hData, 8'h5A);
      look(7'd3);
      chk("reg3_rd", f2hData, 8'hA5);

      // FIFO fill and full hold
      for (int i = 1; i <= 16; i++) step(7'(FC), 1'b1, 8'(i), 1'b0);
      look(7'(FC));
      chk("full_ready", h2fReady, 0);
      chk("full_count", fifoCount, 16);
      step(7'(FC), 1'b1, 8'h11, 1'b0);
      look(7'(SC));
      chk("full_status", f2hData, 8'h90);
      chk("full_count_held", fifoCount, 16);

      // FIFO drain in order
      for (int i = 1; i <= 16; i++) begin
         look(7'(FC));
         chk("drain_valid", f2hValid, 1);
         chk("drain_data", f2hData, 8'(i));
         step(7'(FC), 1'b0, 8'h00, 1'b1);
      end
      look(7'(FC));
      chk("empty_valid", f2hValid, 0);
      chk("empty_data", f2hData, 8'h00);
      look(7'(SC));
      chk("empty_status", f2hData, 8'h40);
      step(7'(FC), 1'b1, 8'h11, 1'b0);
      look(7'(FC));
      chk("retry_head", f2hData, 8'h11);
      step(7'(FC), 1'b0, 8'h00, 1'b1);

      // Pointer wrap with concurrent push/pop
      for (int i = 0; i < 10; i++) step(7'(FC), 1'b1, 8'(8'h20 + i), 1'b0);
      for (int i = 0; i < 10; i++) step(7'(FC), 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 12; i++) step(7'(FC), 1'b1, 8'(8'h40 + i), (i % 2) == 1);
      look(7'(FC));
      chk("wrap_count", fifoCount, 6);
      chk("wrap_head", f2hData, 8'h46);
      guard = 0;
      while (q.size() > 0 && guard < 64) begin
         step(7'(FC), 1'b0, 8'h00, 1'b1);
         guard++;
      end
      chk("wrap_drain_bound", guard < 64, 1);

      // Status-channel write: flush when enabled, discarded otherwise
      for (int i = 0; i < 5; i++) step(7'(FC), 1'b1, 8'(8'h70 + i), 1'b0);
      step(7'(SC), 1'b1, 8'hFF, 1'b0);
      look(7'(FC));
`ifdef CHAN_REGFIFO_FLUSH_EN
      chk("flush_count", fifoCount, 0);
      chk("flush_valid", f2hValid, 0);
`else
      chk("noflush_count", fifoCount, 5);
      chk("noflush_head", f2hData, 8'h70);
`endif
      guard = 0;
      while (q.size() > 0 && guard < 64) begin
         step(7'(FC), 1'b0, 8'h00, 1'b1);
         guard++;
      end

      // Unmapped channel
      step(7'd100, 1'b1, 8'h33, 1'b0);
      look(7'd100);
      chk("unmap_data", f2hData, 8'h00);
      chk("unmap_ready", h2fReady, 1);
      chk("unmap_valid", f2hValid, 1);
      chk("unmap_regs", regs_out[31:24], 8'hA5);

      // Reset in the middle of a transfer
      for (int i = 0; i < 3; i++) step(7'(FC), 1'b1, 8'(8'h90 + i), 1'b0);
      #3;
      reset_n = 1'b0;
      mreset();
      #1;
      chk("midrst_count", fifoCount, 0);
      chk("midrst_regs", regs_out, 0);
      @(negedge clk);
      #1;
      h2fValid = 1'b0;
      @(negedge clk);
      #1 reset_n = 1'b1;
      look(7'(SC));
      chk("midrst_status", f2hData, 8'h40);
      look(7'(FC));
      chk("midrst_valid", f2hValid, 0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chan_regfifo.md
Name: chan_regfifo

Overview:
- Parametrised successor to the switches/LEDs application. It sits on the same chanAddr/h2f/f2h channel interface behind comm_fpga_fx2.
- Provides NUM_REGS read/write byte registers, one streaming loopback FIFO channel, and one read-only status channel.
- Register contents are exported as a flat bus for board peripherals (LEDs, seven-segment, etc.).

Parameters:
- NUM_REGS, 8, number of register channels at addresses 0..NUM_REGS-1; legal range 1..64.
- FIFO_CHAN, 64, channel address of the FIFO; must be >= NUM_REGS and <= 127.
- STAT_CHAN, 65, channel address of the status byte; must differ from FIFO_CHAN and be >= NUM_REGS.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..32.

Ports:
- clk_in  in  1  system clock, 48MHz FX2 clock domain
- reset_in  in  1  asynchronous, active-low reset
- chanAddr_in  in  7  selected channel
- h2fData_in  in  8  host-to-FPGA data
- h2fValid_in  in  1  host offers h2fData_in this cycle
- h2fReady_out  out  1  block accepts h2f data this cycle
- f2hData_out  out  8  FPGA-to-host data
- f2hValid_out  out  1  f2hData_out is valid
- f2hReady_in  in  1  host consumes f2hData_out on this edge
- regs_out  out  8*NUM_REGS  register i on bits [8i+7:8i]
- fifoCount_out  out  6  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (reset_in=0, asynchronous assert, release synchronous to clk_in):
  - all registers become 0x00; FIFO empties (rd ptr = wr ptr = 0, count = 0).
  - Outputs: regs_out=0, fifoCount_out=0, h2fReady_out=1, f2hValid_out=1, f2hData_out=0x00 (channel 0 register).
- Reset mid-transfer: FIFO contents are lost; any in-flight byte is dropped; no partial state survives.
- Write acceptance: a write is accepted on a rising edge with h2fValid_in=1 and h2fReady_out=1.
- Read acceptance: a read is consumed on a rising edge with f2hValid_in=1 and f2hReady_in=1.
- Register channel i < NUM_REGS:
  - h2fReady_out=1 always.
  - An accepted write updates reg i on that edge; it is visible on regs_out and readback from the next cycle.
  - Reads: f2hValid_out=1; f2hData_out=reg i, combinational from chanAddr_in.
- FIFO channel:
  - h2fReady_out = !full; an accepted write pushes h2fData_in.
  - f2hValid_out = !empty; f2hData_out = head entry (first-word-fall-through); an accepted read pops.
  - Full: h2fReady_out=0, no push, no overwrite.
  - Empty: f2hValid_out=0; f2hData_out=0x00 (don't-care, but driven).
  - Simultaneous push and pop in one cycle: both occur and count is unchanged. When full, no push occurs (no bypass). When empty, no pop occurs.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is held separately (6 bits).
- Status channel: f2hValid_out=1; f2hData_out = {full, empty, count[5:0]}. Reads have no side effect. Write behaviour is set by FLUSH (see Optional Feature).
- Unmapped channels: h2fReady_out=1 and writes are discarded; f2hValid_out=1 with data 0x00.
- fifoCount_out is registered; it equals the internal count and updates on the edge after a push or pop.
- Latency: register write to regs_out is 1 edge; FIFO push to data visible at head is 1 edge.
- Handshake signals and f2hData_out are combinational from chanAddr_in and state only. There is no combinational path from h2fValid_in or f2hReady_in to any output.

Optional Feature:
- Macro: CHAN_REGFIFO_FLUSH_EN.
- Defined: an accepted write to STAT_CHAN (any data) empties the FIFO on that edge (pointers and count to 0). If a pop coincides with the flush, the flush wins.
- Undefined: writes to STAT_CHAN are accepted and discarded; the FIFO is unaffected.

Decomposition:
- Package chan_regfifo_pkg holds:
  - CHAN_W=7, DATA_W=8, COUNT_W=6;
  - status bit positions STAT_FULL_BIT=7, STAT_EMPTY_BIT=6;
  - a clog2 function.
- One sub-module, fifo_fwft (params DEPTH, DATA_W): push/pop/full/empty/count/head, with the same clk_in/reset_in.
- Channel decode and the register bank stay in chan_regfifo.

Test Plan:
- Reset: hold reset_in=0, then release -> regs_out=0, fifoCount_out=0, h2fReady_out=1, f2hValid_out=1; status read returns 0x40.
- Register path: write 0xA5 to chan 3, then 0x5A to chan 0 -> regs_out[31:24]=0xA5, [7:0]=0x5A one edge later; reads of chans 3 and 0 return the same values.
- FIFO fill: push 0x01..0x10 (16 bytes) to FIFO_CHAN -> h2fReady_out=0 after the 16th; a 17th write is held and not lost; status reads 0x90.
- FIFO drain: pop 16 bytes -> data 0x01..0x10 in order; then f2hValid_out=0 and status reads 0x40.
- Wrap and concurrent push/pop: push 10, pop 10, push 12 with concurrent push+pop cycles forced -> FIFO order preserved across the pointer wrap; count never exceeds 16.
- Flush (CHAN_REGFIFO_FLUSH_EN defined): push 5, then write 0xFF to STAT_CHAN -> fifoCount_out=0 next cycle and f2hValid_out=0 on FIFO_CHAN. With the macro undefined -> count stays 5.
